// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, status flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_NAND = 4'd4,
        OP_NOR  = 4'd5,
        OP_XOR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_NOT  = 4'd9,
        OP_NEG  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_V  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps per operation.
// done is high during the cycle whose closing edge takes the final step.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    logic [PROD_W-1:0] mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CNT_W-1:0]  cnt_q;

    // Multiplicand walks left, multiplier walks right; add when the multiplier LSB is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            mcand_q  <= PROD_W'(a);
            mplier_q <= b;
            cnt_q    <= '0;
            product  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            if (mplier_q[0]) begin
                product <= product + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            done     <= (cnt_q == CNT_W'(WIDTH - 2));
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with Z/N/C/V flags and illegal-opcode reporting.
// Define ALU_PIPE_MUL_EN to add the iterative multiplier (opcode 11); otherwise opcode 11 is illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPC_W-1:0]     in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [FLAGS_W-1:0]   out_flags,
    output logic                 out_illegal
);

    localparam int unsigned EXT_W   = WIDTH + 1;
    localparam int unsigned SHAMT_W = 8;
    localparam int unsigned MSB     = WIDTH - 1;

    logic                 accept;
    logic [SHAMT_W-1:0]   shamt;
    logic                 shamt_zero;
    logic                 shamt_big;
    logic [EXT_W-1:0]     add_sum;
    logic [EXT_W-1:0]     sub_sum;
    logic [EXT_W-1:0]     neg_sum;
    logic [EXT_W-1:0]     shl_ext;
    logic [EXT_W-1:0]     shr_ext;
    logic [WIDTH-1:0]     op_result;
    logic [FLAGS_W-1:0]   op_flags;
    logic                 op_c;
    logic                 op_v;
    logic                 op_illegal;

    logic                 out_valid_nxt;
    logic [WIDTH-1:0]     out_result_nxt;
    logic [FLAGS_W-1:0]   out_flags_nxt;
    logic                 out_illegal_nxt;

`ifdef ALU_PIPE_MUL_EN
    alu_state_e           state_q;
    alu_state_e           state_nxt;
    logic                 op_is_mul;
    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [FLAGS_W-1:0]   mul_flags;

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign in_ready = (state_q == ST_IDLE) && !mul_busy && (!out_valid || out_ready);

    // Multiplier overflow: any bit in the high product half sets both C and V.
    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
        mul_flags[FLAG_N] = mul_product[MSB];
        mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
    end
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign accept = in_valid && in_ready;
    assign shamt  = in_b[SHAMT_W-1:0];

    // Single-cycle datapath; SUB and NEG share the A + ~B + 1 form so C means "no borrow".
    always_comb begin
        op_result  = '0;
        op_c       = 1'b0;
        op_v       = 1'b0;
        op_illegal = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        op_is_mul  = 1'b0;
`endif
        add_sum    = {1'b0, in_a} + {1'b0, in_b};
        sub_sum    = {1'b0, in_a} + {1'b0, ~in_b} + EXT_W'(1);
        neg_sum    = {1'b0, ~in_a} + EXT_W'(1);
        shl_ext    = {1'b0, in_a} << shamt;
        shr_ext    = {in_a, 1'b0} >> shamt;
        shamt_zero = (shamt == '0);
        shamt_big  = (32'(shamt) >= WIDTH);

        case (in_op)
            OPC_W'(OP_ADD): begin
                op_result = add_sum[WIDTH-1:0];
                op_c      = add_sum[WIDTH];
                op_v      = (in_a[MSB] == in_b[MSB]) && (add_sum[MSB] != in_a[MSB]);
            end
            OPC_W'(OP_SUB): begin
                op_result = sub_sum[WIDTH-1:0];
                op_c      = sub_sum[WIDTH];
                op_v      = (in_a[MSB] != in_b[MSB]) && (sub_sum[MSB] != in_a[MSB]);
            end
            OPC_W'(OP_AND):  op_result = in_a & in_b;
            OPC_W'(OP_OR):   op_result = in_a | in_b;
            OPC_W'(OP_NAND): op_result = ~(in_a & in_b);
            OPC_W'(OP_NOR):  op_result = ~(in_a | in_b);
            OPC_W'(OP_XOR):  op_result = in_a ^ in_b;
            OPC_W'(OP_SHL): begin
                if (!shamt_big) begin
                    op_result = shl_ext[WIDTH-1:0];
                    op_c      = !shamt_zero && shl_ext[WIDTH];
                end
            end
            OPC_W'(OP_SHR): begin
                if (!shamt_big) begin
                    op_result = shr_ext[WIDTH:1];
                    op_c      = !shamt_zero && shr_ext[0];
                end
            end
            OPC_W'(OP_NOT):  op_result = ~in_a;
            OPC_W'(OP_NEG): begin
                op_result = neg_sum[WIDTH-1:0];
                op_c      = neg_sum[WIDTH];
                op_v      = in_a[MSB] && neg_sum[MSB];
            end
`ifdef ALU_PIPE_MUL_EN
            OPC_W'(OP_MUL):  op_is_mul = 1'b1;
`endif
            default:         op_illegal = 1'b1;
        endcase

        op_flags = '0;
        if (!op_illegal) begin
            op_flags[FLAG_Z] = (op_result == '0);
            op_flags[FLAG_N] = op_result[MSB];
            op_flags[FLAG_C] = op_c;
            op_flags[FLAG_V] = op_v;
        end
    end

    // Next-state and output register inputs; results are held until transferred.
    always_comb begin
        out_valid_nxt   = out_valid;
        out_result_nxt  = out_result;
        out_flags_nxt   = out_flags;
        out_illegal_nxt = out_illegal;
`ifdef ALU_PIPE_MUL_EN
        state_nxt       = state_q;
        mul_start       = 1'b0;
`endif

        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

`ifdef ALU_PIPE_MUL_EN
        case (state_q)
            ST_IDLE: begin
                if (accept && op_is_mul) begin
                    mul_start = 1'b1;
                    state_nxt = ST_MUL;
                end else if (accept) begin
                    out_valid_nxt   = 1'b1;
                    out_result_nxt  = op_result;
                    out_flags_nxt   = op_flags;
                    out_illegal_nxt = op_illegal;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_nxt   = 1'b1;
                out_result_nxt  = mul_product[WIDTH-1:0];
                out_flags_nxt   = mul_flags;
                out_illegal_nxt = 1'b0;
                state_nxt       = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
`else
        if (accept) begin
            out_valid_nxt   = 1'b1;
            out_result_nxt  = op_result;
            out_flags_nxt   = op_flags;
            out_illegal_nxt = op_illegal;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            out_illegal <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= ST_IDLE;
`endif
        end else begin
            out_valid   <= out_valid_nxt;
            out_result  <= out_result_nxt;
            out_flags   <= out_flags_nxt;
            out_illegal <= out_illegal_nxt;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= state_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); follows ALU_PIPE_MUL_EN for opcode 11 expectations.
module tb_alu_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flags;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic        out_illegal;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_pipe #(
        .WIDTH (16),
        .OPC_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model in plain integer arithmetic; flags are {V,C,N,Z}.
    function automatic exp_t model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int unsigned ua, ub, r, p, amt;
        int          sa, sb, s;
        bit          c, v, ill;
        ua = a; ub = b; amt = b[7:0];
        sa = $signed(a); sb = $signed(b);
        r = 0; c = 0; v = 0; ill = 0;
        case (op)
            8'd0: begin r = ua + ub; c = (r > 32'hFFFF); s = sa + sb; v = (s > 32767) || (s < -32768); end
            8'd1: begin r = ua - ub; c = (ua >= ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
            8'd2: r = ua & ub;
            8'd3: r = ua | ub;
            8'd4: r = ~(ua & ub);
            8'd5: r = ~(ua | ub);
            8'd6: r = ua ^ ub;
            8'd7: begin
                r = (amt >= 16) ? 0 : (ua << amt);
                c = (amt > 0 && amt < 16) ? (((ua >> (16 - amt)) & 1) != 0) : 1'b0;
            end
            8'd8: begin
                r = (amt >= 16) ? 0 : (ua >> amt);
                c = (amt > 0 && amt < 16) ? (((ua >> (amt - 1)) & 1) != 0) : 1'b0;
            end
            8'd9:  r = ~ua;
            8'd10: begin r = 0 - ua; c = (ua == 0); v = (ua == 32'h8000); end
`ifdef ALU_PIPE_MUL_EN
            8'd11: begin p = ua * ub; r = p; c = ((p >> 16) != 0); v = c; end
`endif
            default: ill = 1;
        endcase
        e.res   = ill ? 16'h0 : r[15:0];
        e.flags = ill ? 4'h0 : {v, c, r[15], (r[15:0] == 16'h0)};
        e.ill   = ill;
        return e;
    endfunction

    // Offer one operation, wait (bounded) for acceptance, push its expected result.
    task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b, output int waited);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(model(op, a, b));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Output monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("result", 32'(out_result), 32'(mon_e.res));
                check("flags", 32'(out_flags), 32'(mon_e.flags));
                check("illegal", 32'(out_illegal), 32'(mon_e.ill));
            end
        end
    end

    initial begin
        int  w0, w1, w2, n, cyc;
        bit  seen_ready, stale, rnd_done;
        logic [7:0] rop;
        logic [15:0] rb;

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        rnd_done = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_result", 32'(out_result), 32'd0);
        check("rst out_flags", 32'(out_flags), 32'd0);
        check("rst out_illegal", 32'(out_illegal), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ADD with signed overflow, latency 1
        send(8'd0, 16'h7FFF, 16'h0001, w0);
        check("add valid lat1", 32'(out_valid), 32'd1);
        check("add result", 32'(out_result), 32'h8000);
        check("add flags", 32'(out_flags), 32'b1010);
        check("add illegal", 32'(out_illegal), 32'd0);

        // SUB then SHR back-to-back
        send(8'd1, 16'h0005, 16'h0005, w0);
        check("sub result", 32'(out_result), 32'h0000);
        check("sub flags", 32'(out_flags), 32'b0101);
        send(8'd8, 16'h8001, 16'h0001, w1);
        check("b2b ready 0", 32'(w0), 32'd0);
        check("b2b ready 1", 32'(w1), 32'd0);
        check("shr result", 32'(out_result), 32'h4000);
        check("shr flags", 32'(out_flags), 32'b0100);

        // Backpressure: XOR held for 3 cycles, next op accepted only once out_ready rises
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'd6, 16'h00FF, 16'h0F0F, w0);
        fork
            send(8'd0, 16'h0001, 16'h0002, w2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp hold result", 32'(out_result), 32'h0FF0);
                    check("bp hold valid", 32'(out_valid), 32'd1);
                    check("bp in_ready low", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp accept cycle", 32'(w2), 32'd3);

`ifdef ALU_PIPE_MUL_EN
        // MUL: latency WIDTH+1, in_ready low while busy
        send(8'd11, 16'h0123, 16'h0010, w0);
        n = 0; seen_ready = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) seen_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check("mul latency", 32'(n), 32'd17);
        check("mul in_ready low", 32'(seen_ready), 32'd0);
        check("mul result", 32'(out_result), 32'h1230);
        check("mul flags", 32'(out_flags), 32'd0);
        send(8'd11, 16'hFFFF, 16'h0003, w0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mul ovf flags", 32'(out_flags), 32'b1110);
`else
        send(8'd11, 16'h0123, 16'h0010, w0);
        check("op11 lat1 valid", 32'(out_valid), 32'd1);
        check("op11 illegal", 32'(out_illegal), 32'd1);
        check("op11 result", 32'(out_result), 32'd0);
`endif
        send(8'h0C, 16'h1234, 16'h5678, w0);
        check("op12 lat1 valid", 32'(out_valid), 32'd1);
        check("op12 illegal", 32'(out_illegal), 32'd1);
        check("op12 result", 32'(out_result), 32'd0);
        check("op12 flags", 32'(out_flags), 32'd0);

        // Shift boundaries and remaining ops, checked through the scoreboard
        send(8'd7,  16'h8001, 16'd1,   w0);
        send(8'd7,  16'h1234, 16'd0,   w0);
        send(8'd7,  16'hFFFF, 16'd16,  w0);
        send(8'd7,  16'h0003, 16'd15,  w0);
        send(8'd8,  16'hFFFF, 16'd255, w0);
        send(8'd8,  16'h8000, 16'd15,  w0);
        send(8'd8,  16'h00F0, 16'h0100, w0);
        send(8'd10, 16'h8000, 16'd0,   w0);
        send(8'd10, 16'h0000, 16'd0,   w0);
        send(8'd10, 16'h0001, 16'd0,   w0);
        send(8'd9,  16'hA5A5, 16'd0,   w0);
        send(8'd4,  16'hFFFF, 16'hFFFF, w0);
        send(8'd5,  16'h0000, 16'h0000, w0);
        send(8'd2,  16'hF0F0, 16'h3C3C, w0);
        send(8'd3,  16'hF000, 16'h000F, w0);
        send(8'd1,  16'h0003, 16'h0005, w0);
        send(8'd1,  16'h8000, 16'h0001, w0);
        send(8'd0,  16'hFFFF, 16'h0001, w0);
        send(8'hFF, 16'hFFFF, 16'hFFFF, w0);

        // Asynchronous reset with a result pending
        @(posedge clk);
        #1;
        send(8'd0, 16'h7FFF, 16'h0001, w0);
        check("pre-rst flags", 32'(out_flags), 32'b1010);
        out_ready = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(8'd11, 16'h00FF, 16'h00FF, w0);
        repeat (4) @(posedge clk);
`else
        @(posedge clk);
        #1;
`endif
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_flags", 32'(out_flags), 32'd0);
        check("async rst out_result", 32'(out_result), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst release in_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("no stale result", 32'(stale), 32'd0);

        // Random traffic with random backpressure
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    rop = 8'($urandom_range(0, 12));
                    rb  = (rop == 8'd7 || rop == 8'd8) ? 16'($urandom_range(0, 20)) : 16'($urandom);
                    send(rop, 16'($urandom), rb, w0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join

        cyc = 0;
        while (sb_q.size() > 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
